// File: rtl/lane_cars_ctrl_pkg.sv
// Shared types and defaults for the lane car controller.
// Also holds the step-period helper used for level scaling.
package lane_cars_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StFreeze = 2'd2
    } state_e;

    localparam int unsigned c_DEF_GAME_WIDTH   = 640;
    localparam int unsigned c_DEF_CAR_WIDTH    = 64;
    localparam int unsigned c_DEF_CAR_HEIGHT   = 32;
    localparam int unsigned c_DEF_BASE_PERIOD  = 1650000;
    localparam int unsigned c_DEF_LEVEL_STEP   = 150000;
    localparam int unsigned c_DEF_MIN_PERIOD   = 300000;
    localparam int unsigned c_DEF_FREEZE_STEPS = 60;

    // max(base - level*step, min) without wrapping below zero; never returns 0
    function automatic logic [31:0] step_period(input logic [31:0] base,
                                                input logic [31:0] lvl_step,
                                                input logic [31:0] min_p,
                                                input logic [2:0]  level);
        logic [34:0] w_dec;
        logic [31:0] w_per;
        w_dec = 35'(level) * 35'(lvl_step);
        if (w_dec >= 35'(base)) begin
            w_per = min_p;
        end else begin
            w_per = base - w_dec[31:0];
        end
        if (w_per < min_p) begin
            w_per = min_p;
        end
        if (w_per == '0) begin
            w_per = 32'd1;
        end
        return w_per;
    endfunction

endpackage

// File: rtl/lane_cars_ctrl_if.sv
// Pixel-path bundle between the video scan logic and a lane controller.
interface lane_cars_ctrl_if ();

    logic [9:0] i_Col_Count_Div;
    logic [9:0] i_Row_Count_Div;
    logic       i_Draw_Frog;
    logic       o_Draw_car;
    logic       o_Hit;

    modport slave (
        input  i_Col_Count_Div,
        input  i_Row_Count_Div,
        input  i_Draw_Frog,
        output o_Draw_car,
        output o_Hit
    );

    modport master (
        output i_Col_Count_Div,
        output i_Row_Count_Div,
        output i_Draw_Frog,
        input  o_Draw_car,
        input  o_Hit
    );

endinterface

// File: rtl/car_sprite_rom.sv
// Combinational car bitmap: a body plus a narrower hood at the high-column (front) end.
module car_sprite_rom #(
    parameter int unsigned c_CAR_WIDTH  = 64,
    parameter int unsigned c_CAR_HEIGHT = 32,
    parameter int unsigned c_ROW_AW     = $clog2(c_CAR_HEIGHT),
    parameter int unsigned c_COL_AW     = $clog2(c_CAR_WIDTH)
) (
    input  logic [c_ROW_AW-1:0] i_Row,
    input  logic [c_COL_AW-1:0] i_Col,
    output logic                o_Pixel
);

    logic [31:0] w_r;
    logic [31:0] w_c;

    assign w_r = 32'(i_Row);
    assign w_c = 32'(i_Col);

    always_comb begin
        o_Pixel = 1'b0;
        if (w_r >= c_CAR_HEIGHT / 8 && w_r < c_CAR_HEIGHT - c_CAR_HEIGHT / 8 &&
            w_c < c_CAR_WIDTH - c_CAR_WIDTH / 8) begin
            o_Pixel = 1'b1;
        end else if (w_r >= c_CAR_HEIGHT / 4 && w_r < c_CAR_HEIGHT - c_CAR_HEIGHT / 4 &&
                     w_c >= c_CAR_WIDTH - c_CAR_WIDTH / 8 && w_c < c_CAR_WIDTH) begin
            o_Pixel = 1'b1;
        end
    end

endmodule

// File: rtl/lane_cars_ctrl.sv
// One traffic lane: several cars moving together, drawn per pixel, with frog-hit detection
// and a post-hit freeze.
module lane_cars_ctrl
    import lane_cars_ctrl_pkg::*;
#(
    parameter int unsigned c_GAME_WIDTH   = c_DEF_GAME_WIDTH,
    parameter int unsigned c_NUM_CARS     = 3,
    parameter int unsigned c_CAR_WIDTH    = c_DEF_CAR_WIDTH,
    parameter int unsigned c_CAR_HEIGHT   = c_DEF_CAR_HEIGHT,
    parameter int unsigned c_INIT_X       = 0,
    parameter int unsigned c_SPACING      = 213,
    parameter int unsigned c_DIRECTION    = 0,
    parameter int unsigned c_BASE_PERIOD  = c_DEF_BASE_PERIOD,
    parameter int unsigned c_LEVEL_STEP   = c_DEF_LEVEL_STEP,
    parameter int unsigned c_MIN_PERIOD   = c_DEF_MIN_PERIOD,
    parameter int unsigned c_FREEZE_STEPS = c_DEF_FREEZE_STEPS
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic                   i_Game_Active,
    input  logic [2:0]             i_Level,
    input  logic [9:0]             i_Lane_Y,
    lane_cars_ctrl_if.slave        io_Pix,
    output logic [9:0]             o_Lead_X,
    output logic                   o_Frozen
);

    localparam int unsigned c_ROW_AW     = $clog2(c_CAR_HEIGHT);
    localparam int unsigned c_COL_AW     = $clog2(c_CAR_WIDTH);
    localparam logic [31:0] c_PERIOD_RST = step_period(32'(c_BASE_PERIOD), 32'(c_LEVEL_STEP),
                                                       32'(c_MIN_PERIOD), 3'd0);

    state_e                r_state;
    state_e                w_state_next;
    logic [31:0]           r_step_cnt;
    logic [31:0]           r_period;
    logic [31:0]           r_frz_cnt;
    logic [9:0]            r_lane_y;
    logic                  r_draw;
    logic                  r_hit;
    logic [31:0]           w_period_new;
    logic                  w_period_end;
    logic                  w_step;
    logic                  w_hit;
    logic                  w_frz_enter;
    logic                  w_reload;
    logic [c_NUM_CARS-1:0] w_car_px;

    assign w_period_new = step_period(32'(c_BASE_PERIOD), 32'(c_LEVEL_STEP),
                                      32'(c_MIN_PERIOD), i_Level);
    assign w_period_end = (r_step_cnt == r_period - 32'd1);
    assign w_step       = (r_state == StRun) && w_period_end;
    assign w_hit        = (r_state == StRun) && r_draw && io_Pix.i_Draw_Frog;
    assign w_frz_enter  = (r_state == StRun) && (w_state_next == StFreeze);
    // Entering freeze restarts the period so the freeze lasts whole periods
    assign w_reload     = w_period_end || w_frz_enter;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_Game_Active) w_state_next = StRun;
            end
            StRun: begin
                if (!i_Game_Active) w_state_next = StIdle;
                else if (w_hit && c_FREEZE_STEPS > 0) w_state_next = StFreeze;
            end
            StFreeze: begin
                if (!i_Game_Active) w_state_next = StIdle;
                else if (w_period_end && r_frz_cnt == c_FREEZE_STEPS - 1) w_state_next = StRun;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_state    <= StIdle;
            r_step_cnt <= '0;
            r_frz_cnt  <= '0;
            r_period   <= c_PERIOD_RST;
            r_lane_y   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle) begin
                r_step_cnt <= '0;
                r_frz_cnt  <= '0;
                r_period   <= w_period_new;
                r_lane_y   <= i_Lane_Y;
            end else if (w_reload) begin
                r_step_cnt <= '0;
                r_period   <= w_period_new;
                if (w_frz_enter) r_frz_cnt <= '0;
                else if (r_state == StFreeze) r_frz_cnt <= r_frz_cnt + 32'd1;
            end else begin
                r_step_cnt <= r_step_cnt + 32'd1;
            end
        end
    end

    for (genvar k = 0; k < c_NUM_CARS; k++) begin : g_car
        localparam logic [9:0] c_START = 10'((c_INIT_X + k * c_SPACING) % c_GAME_WIDTH);

        logic [9:0]          r_x;
        logic [9:0]          w_x_next;
        logic [9:0]          w_dr;
        logic [10:0]         w_dc;
        logic [c_COL_AW-1:0] w_rom_col;
        logic                w_cov;
        logic                w_bit;

        assign w_x_next = (c_DIRECTION == 0) ?
                          ((r_x == 10'(c_GAME_WIDTH - 1)) ? 10'd0 : r_x + 10'd1) :
                          ((r_x == 10'd0) ? 10'(c_GAME_WIDTH - 1) : r_x - 10'd1);

        always_ff @(posedge i_Clk) begin
            if (!i_Rst_n || r_state == StIdle) begin
                r_x <= c_START;
            end else if (w_step) begin
                r_x <= w_x_next;
            end
        end

        // Column offset taken modulo the playfield so a car crossing the edge draws its tail
        assign w_dr = io_Pix.i_Row_Count_Div - r_lane_y;
        assign w_dc = (io_Pix.i_Col_Count_Div >= r_x) ?
                      {1'b0, io_Pix.i_Col_Count_Div - r_x} :
                      {1'b0, io_Pix.i_Col_Count_Div} + 11'(c_GAME_WIDTH) - {1'b0, r_x};
        assign w_cov = (w_dr < 10'(c_CAR_HEIGHT)) && (w_dc < 11'(c_CAR_WIDTH));
        assign w_rom_col = (c_DIRECTION == 0) ? w_dc[c_COL_AW-1:0] :
                           c_COL_AW'(c_CAR_WIDTH - 1) - w_dc[c_COL_AW-1:0];

        car_sprite_rom #(
            .c_CAR_WIDTH  (c_CAR_WIDTH),
            .c_CAR_HEIGHT (c_CAR_HEIGHT),
            .c_ROW_AW     (c_ROW_AW),
            .c_COL_AW     (c_COL_AW)
        ) u_rom (
            .i_Row   (w_dr[c_ROW_AW-1:0]),
            .i_Col   (w_rom_col),
            .o_Pixel (w_bit)
        );

        assign w_car_px[k] = w_cov & w_bit;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_draw <= 1'b0;
            r_hit  <= 1'b0;
        end else begin
            r_draw <= |w_car_px;
            r_hit  <= w_hit;
        end
    end

    assign io_Pix.o_Draw_car = r_draw;
    assign io_Pix.o_Hit      = r_hit;
    assign o_Lead_X          = g_car[0].r_x;
    assign o_Frozen          = (r_state == StFreeze);

endmodule

// File: tb/tb_lane_cars_ctrl.sv
// Directed bench: a rightward 3-car lane and a leftward 1-car lane with short step periods.
module tb_lane_cars_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       game0;
    logic       game1;
    logic [2:0] level;
    logic [9:0] lane_y;
    logic [9:0] lead0;
    logic [9:0] lead1;
    logic       frozen0;
    logic       frozen1;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    lane_cars_ctrl_if pix0 ();
    lane_cars_ctrl_if pix1 ();

    lane_cars_ctrl #(
        .c_NUM_CARS     (3),
        .c_INIT_X       (0),
        .c_SPACING      (213),
        .c_DIRECTION    (0),
        .c_BASE_PERIOD  (10),
        .c_LEVEL_STEP   (2),
        .c_MIN_PERIOD   (4),
        .c_FREEZE_STEPS (3)
    ) u_dut0 (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Game_Active (game0),
        .i_Level       (level),
        .i_Lane_Y      (lane_y),
        .io_Pix        (pix0),
        .o_Lead_X      (lead0),
        .o_Frozen      (frozen0)
    );

    lane_cars_ctrl #(
        .c_NUM_CARS     (1),
        .c_INIT_X       (100),
        .c_SPACING      (213),
        .c_DIRECTION    (1),
        .c_BASE_PERIOD  (10),
        .c_LEVEL_STEP   (2),
        .c_MIN_PERIOD   (4),
        .c_FREEZE_STEPS (3)
    ) u_dut1 (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Game_Active (game1),
        .i_Level       (level),
        .i_Lane_Y      (lane_y),
        .io_Pix        (pix1),
        .o_Lead_X      (lead1),
        .o_Frozen      (frozen1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int col, input int row, input logic f);
        pix0.i_Col_Count_Div = 10'(col);
        pix0.i_Row_Count_Div = 10'(row);
        pix0.i_Draw_Frog     = f;
        pix1.i_Col_Count_Div = 10'(col);
        pix1.i_Row_Count_Div = 10'(row);
        pix1.i_Draw_Frog     = f;
    endtask

    task automatic pix_check(input int which, input int col, input int row, input logic exp,
                             input string tag);
        set_pix(col, row, 1'b0);
        tick(1);
        check(tag, (which == 0) ? pix0.o_Draw_car : pix1.o_Draw_car, exp);
    endtask

    task automatic wait_lead(input int which, input logic [9:0] val, input int budget,
                             input string tag);
        int n = 0;
        while (((which == 0) ? lead0 : lead1) != val && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, (which == 0) ? lead0 : lead1, val);
    endtask

    initial begin
        rst_n  = 1'b0;
        game0  = 1'b0;
        game1  = 1'b0;
        level  = 3'd5;
        lane_y = 10'd100;
        set_pix(0, 0, 1'b0);
        tick(2);
        check("rst_draw0", pix0.o_Draw_car, 0);
        check("rst_hit0", pix0.o_Hit, 0);
        check("rst_frozen0", frozen0, 0);
        check("rst_lead0", lead0, 0);
        check("rst_lead1", lead1, 100);

        rst_n = 1'b1;
        tick(1);
        check("rel_lead0", lead0, 0);
        check("rel_draw0", pix0.o_Draw_car, 0);
        check("rel_hit0", pix0.o_Hit, 0);
        check("rel_frozen0", frozen0, 0);

        // Idle start positions 0/213/426, lane top row 100
        pix_check(0, 218, 105, 1'b1, "idle_car1");
        pix_check(0, 486, 105, 1'b0, "idle_car2_r5");
        pix_check(0, 486, 110, 1'b1, "idle_car2_r10");
        pix_check(0, 100,  99, 1'b0, "idle_above");
        pix_check(0,  10, 127, 1'b1, "idle_r27");
        pix_check(0,  10, 128, 1'b0, "idle_r28");
        pix_check(0,  63, 110, 1'b1, "idle_c63");
        pix_check(0,  64, 110, 1'b0, "idle_c64");

        // Leftward car at 100: sprite mirrored
        pix_check(1, 100, 105, 1'b0, "mir_c0_r5");
        pix_check(1, 100, 110, 1'b1, "mir_c0_r10");
        pix_check(1, 163, 105, 1'b1, "mir_c63_r5");
        pix_check(1, 164, 105, 1'b0, "mir_c64");
        pix_check(1,  99, 110, 1'b0, "mir_left");

        game1 = 1'b1;
        tick(4);
        check("l_hold", lead1, 100);
        tick(1);
        check("l_step", lead1, 99);
        wait_lead(1, 10'd0, 600, "l_reach0");
        tick(3);
        check("l_wrap_hold", lead1, 0);
        tick(1);
        check("l_wrap", lead1, 639);
        game1 = 1'b0;
        tick(2);
        check("l_idle", lead1, 100);

        // Level 5 -> period 4; level 1 -> period 8, taking effect at the next reload
        set_pix(63, 110, 1'b0);
        game0 = 1'b1;
        tick(1);
        check("r_enter", lead0, 0);
        tick(3);
        check("p4_hold", lead0, 0);
        tick(1);
        check("p4_step", lead0, 1);
        level = 3'd1;
        tick(4);
        check("p4_again", lead0, 2);
        tick(7);
        check("p8_hold", lead0, 2);
        tick(1);
        check("p8_step", lead0, 3);
        level = 3'd5;
        wait_lead(0, 10'd600, 3000, "reach600");
        level = 3'd0;
        wait_lead(0, 10'd620, 400, "reach620");

        // Car 0 at 620 spans the edge: columns 0..43 show sprite columns 20..63
        pix_check(0,   0, 105, 1'b1, "edge_c20");
        pix_check(0,  35, 105, 1'b1, "edge_c55");
        pix_check(0,  36, 105, 1'b0, "edge_c56_r5");
        pix_check(0,  43, 110, 1'b1, "edge_c63");
        pix_check(0,  44, 110, 1'b0, "edge_c64");
        pix_check(0, 619, 110, 1'b0, "edge_before");
        pix_check(0, 620, 110, 1'b1, "edge_c0");

        wait_lead(0, 10'd639, 400, "reach639");
        tick(9);
        check("wrap_hold", lead0, 639);
        tick(1);
        check("wrap", lead0, 0);

        // Hit then freeze for 3 periods of 10
        pix_check(0, 10, 110, 1'b1, "hit_px");
        set_pix(10, 110, 1'b1);
        tick(1);
        check("hit_pulse", pix0.o_Hit, 1);
        check("frz_on", frozen0, 1);
        check("frz_x", lead0, 0);
        tick(1);
        check("hit_once", pix0.o_Hit, 0);
        check("frz_still", frozen0, 1);
        set_pix(10, 110, 1'b0);
        tick(28);
        check("frz_hold", frozen0, 1);
        check("frz_x_hold", lead0, 0);
        tick(1);
        check("frz_exit", frozen0, 0);
        check("frz_exit_x", lead0, 0);
        tick(9);
        check("resume_wait", lead0, 0);
        tick(1);
        check("resume_step", lead0, 1);

        // Reset in the middle of a second freeze
        set_pix(10, 110, 1'b1);
        tick(1);
        check("hit2", pix0.o_Hit, 1);
        check("frz2_on", frozen0, 1);
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check("rst_frz", frozen0, 0);
        check("rst_frz_x", lead0, 0);
        check("rst_frz_hit", pix0.o_Hit, 0);
        check("rst_frz_draw", pix0.o_Draw_car, 0);
        tick(1);
        check("rst_prio", frozen0, 0);
        check("rst_prio_hit", pix0.o_Hit, 0);

        rst_n = 1'b1;
        set_pix(10, 110, 1'b0);
        level = 3'd0;
        tick(10);
        check("rel_hold", lead0, 0);
        tick(1);
        check("rel_step", lead0, 1);

        game0 = 1'b0;
        tick(2);
        check("idle_back", lead0, 0);
        set_pix(10, 110, 1'b1);
        tick(2);
        check("idle_nohit", pix0.o_Hit, 0);
        check("idle_draw", pix0.o_Draw_car, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_cars_ctrl.md
LANE_CARS_CTRL -- requirements
Module: lane_cars_ctrl

Interface
REQ-001 SHALL have parameter c_GAME_WIDTH, default 640, meaning horizontal playfield size in divided pixels.
REQ-002 SHALL have parameter c_NUM_CARS, default 3, range 1..8, meaning cars sharing one lane.
REQ-003 SHALL have parameters c_CAR_WIDTH 64 and c_CAR_HEIGHT 32, meaning sprite size.
REQ-004 SHALL have parameters c_INIT_X 0 and c_SPACING 213, meaning car-0 start column and gap between car starts.
REQ-005 SHALL have parameter c_DIRECTION, default 0, meaning 0 = rightward, 1 = leftward.
REQ-006 SHALL have parameters c_BASE_PERIOD 1650000, c_LEVEL_STEP 150000 and c_MIN_PERIOD 300000, meaning clocks per 1-pixel step.
REQ-007 SHALL have parameter c_FREEZE_STEPS, default 60, meaning steps frozen after a hit; 0 disables the freeze.
REQ-008 i_Clk  in  1  system clock; the block uses one clock.
REQ-009 i_Rst_n  in  1  reset, synchronous, active-low.
REQ-010 i_Game_Active  in  1  high = cars run; low = cars held at start positions.
REQ-011 i_Level  in  3  difficulty level.
REQ-012 i_Col_Count_Div, i_Row_Count_Div  in  10 each  current pixel coordinates.
REQ-013 i_Lane_Y  in  10  lane top row.
REQ-014 i_Draw_Frog  in  1  frog pixel, aligned with o_Draw_car.
REQ-015 o_Draw_car  out  1  car pixel opaque.
REQ-016 o_Hit  out  1  one-cycle collision pulse.
REQ-017 o_Lead_X  out  10  car-0 X position, for debugging and other blocks.
REQ-018 o_Frozen  out  1  high while in FREEZE.

Function
REQ-019 Step period SHALL be max(c_BASE_PERIOD - i_Level*c_LEVEL_STEP, c_MIN_PERIOD), computed with at least 32 bits and no underflow.
REQ-020 i_Level SHALL be sampled only when the step counter reloads; a level change mid-period SHALL take effect at the next period.
REQ-021 FSM SHALL have three states: IDLE, RUN, FREEZE.
REQ-022 IDLE -> RUN SHALL occur when i_Game_Active = 1; RUN/FREEZE -> IDLE SHALL occur when i_Game_Active = 0.
REQ-023 In IDLE: car k X = (c_INIT_X + k*c_SPACING) mod c_GAME_WIDTH, lane Y is latched from i_Lane_Y, step counter = 0.
REQ-024 In RUN, on each step the X of every car SHALL move 1 pixel in c_DIRECTION.
REQ-025 Wrap-around: rightward, X = c_GAME_WIDTH-1 -> 0; leftward, X = 0 -> c_GAME_WIDTH-1.
REQ-026 Draw: a pixel SHALL be covered when row offset r = Row - Y is in 0..c_CAR_HEIGHT-1 and column offset c = (Col - X) mod c_GAME_WIDTH is in 0..c_CAR_WIDTH-1, so a car crossing the edge also draws its tail from column 0.
REQ-027 For a covered pixel, o_Draw_car SHALL equal sprite bit [r][c] when c_DIRECTION = 0, and sprite bit [r][c_CAR_WIDTH-1-c] when c_DIRECTION = 1 (mirrored).
REQ-028 o_Draw_car SHALL be the OR over all cars, registered, with 1-clock latency from the pixel coordinates.
REQ-029 o_Hit SHALL pulse 1 clock after a cycle with o_Draw_car = 1 and i_Draw_Frog = 1; o_Hit SHALL NOT pulse in IDLE or FREEZE.
REQ-030 A hit in RUN with c_FREEZE_STEPS > 0 SHALL enter FREEZE: positions hold, step periods are counted, and the FSM returns to RUN after c_FREEZE_STEPS periods.
REQ-031 When a hit and a step occur in the same clock, the step SHALL complete before entering FREEZE.
REQ-032 o_Frozen SHALL be 1 exactly while in FREEZE.

Reset
REQ-033 When i_Rst_n = 0 at a clock edge: FSM = IDLE, positions = IDLE values, counters = 0, o_Draw_car = 0, o_Hit = 0, o_Frozen = 0, o_Lead_X = c_INIT_X mod c_GAME_WIDTH.
REQ-034 Reset asserted mid-step or mid-freeze SHALL abandon the period; no partial move SHALL occur.
REQ-035 Reset SHALL take priority over i_Game_Active and over hits.

Structure
REQ-036 Shared package SHALL hold the FSM state encoding, default game width, default sprite size and default period constants.
REQ-037 The sprite bitmap SHALL be a sub-module car_sprite_rom (combinational or 1-clock read, inputs row and col, output 1 bit); its latency SHALL be absorbed so that REQ-028 holds.
REQ-038 Per-car position registers SHALL be a generate array over c_NUM_CARS.

Verification
REQ-039 Reset release with c_NUM_CARS = 3, c_INIT_X = 0, c_SPACING = 213, i_Game_Active = 0 -> X = 0, 213, 426; all outputs 0.
REQ-040 c_BASE_PERIOD = 10, c_MIN_PERIOD = 4, c_LEVEL_STEP = 2, i_Level = 5 -> one step per 4 clocks; i_Level = 1 -> one step per 8 clocks.
REQ-041 Rightward car at X = 639 steps -> X = 0; before the step, with X = 620 and c_CAR_WIDTH = 64, pixels at Col 0..43 SHALL show sprite columns 20..63.
REQ-042 c_DIRECTION = 1, car at X = 100, Col = 100 -> o_Draw_car equals sprite bit [r][63], one clock later.
REQ-043 i_Draw_Frog = 1 on an opaque car pixel -> o_Hit high for 1 clock and o_Frozen high; X constant for 60 steps, then motion resumes.
REQ-044 i_Rst_n = 0 during FREEZE -> next clock IDLE, X = start values, o_Frozen = 0.
